// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked
// bit transfer and ACK check, driving the open-drain lines through pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned START_TIMEOUT  = 375000,
  parameter int unsigned BIT_TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2clk_i,
  input  logic       ps2dat_i,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int unsigned CntMaxVal =
      (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMaxVal + 1);

  localparam logic [CntW-1:0] CntSat    = {CntW{1'b1}};
  localparam logic [CntW-1:0] InhLast   = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] StartLast = CntW'(START_TIMEOUT - 1);
  localparam logic [CntW-1:0] BitLast   = CntW'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StWait, StAckWait, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      ec_q, ec_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic            dat_oe_q, dat_oe_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  // Idle-high reset values so a released bus never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ec_q     <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ec_q     <= ec_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
    ec_d     = ec_q;
    sh_d     = sh_q;
    par_d    = par_q;
    dat_oe_d = dat_oe_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (tx_valid) begin
          state_d = StInhibit;
          sh_d    = tx_data;
          par_d   = ~^tx_data;
        end
      end
      StInhibit: begin
        if (cnt_q == InhLast) state_d = StReq;
      end
      StReq: begin
        cnt_d    = '0;
        ec_d     = '0;
        dat_oe_d = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (fall) begin
          cnt_d = '0;
          ec_d  = ec_q + 4'd1;
          if (ec_q < 4'd8) begin
            dat_oe_d = ~sh_q[0];
            sh_d     = {1'b0, sh_q[7:1]};
          end else if (ec_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else if (ec_q == 4'd9) begin
            dat_oe_d = 1'b0;
          end else begin
            // Eleventh edge: device must be pulling data low as its ACK.
            dat_oe_d = 1'b0;
            state_d  = dat_s2_q ? StErr : StAckWait;
          end
        end else if ((ec_q == 4'd0 && cnt_q == StartLast) ||
                     (ec_q != 4'd0 && cnt_q == BitLast)) begin
          state_d = StErr;
        end
      end
      StAckWait: begin
        if (clk_s2_q && dat_s2_q) state_d = StDone;
        else if (cnt_q == BitLast) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_ready   = (state_q == StIdle);
    rx_inhibit = (state_q != StIdle);
    tx_done    = (state_q == StDone);
    tx_error   = (state_q == StErr);
    ps2clk_oe  = (state_q == StInhibit) || (state_q == StReq);
    ps2dat_oe  = (state_q == StReq) || ((state_q == StWait) && dat_oe_q);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, table-driven frames, random bytes
// checked against a parity/bit-order model, and reset/back-to-back corner sequences.
module tb_ps2_host_tx;

  localparam int unsigned InhCyc  = 20;
  localparam int unsigned StartTo = 400;
  localparam int unsigned BitTo   = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, rx_inhibit, ps2clk_oe, ps2dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2clk_line, ps2dat_line;

  assign ps2clk_line = ~(ps2clk_oe | dev_clk_low);
  assign ps2dat_line = ~(ps2dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhCyc),
    .START_TIMEOUT (StartTo),
    .BIT_TIMEOUT   (BitTo)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .rx_inhibit(rx_inhibit),
    .ps2clk_i  (ps2clk_line),
    .ps2dat_i  (ps2dat_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse counts, clk_oe low-going run length, ready/inhibit consistency.
  int   done_cnt = 0, err_cnt = 0, err_cyc = 0, rel_cyc = 0;
  int   run = 0, last_run = 0, inv_bad = 0;
  logic clk_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_error === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2clk_oe === 1'b1) begin
      run <= run + 1;
    end else if (clk_oe_prev) begin
      last_run <= run;
      run      <= 0;
      rel_cyc  <= cyc;
    end
    clk_oe_prev <= ps2clk_oe;
    if (rx_inhibit !== ~tx_ready) inv_bad <= inv_bad + 1;
  end

  int errors = 0;
  int checks = 0;
  int fall5_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: data LSB first, odd parity (even count of ones -> 1), stop bit 1.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  task automatic start_frame(input logic [7:0] d);
    int t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    check("accept_ready", 32'(t < 50), 32'd1);
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device: clocks nfall pulses (20 low / 20 high), samples data at each rising edge.
  task automatic dev_frame(input int nfall, input bit ack, input int rst_at,
                           output logic [9:0] bits);
    int t = 0;
    bits = '0;
    while (ps2clk_line !== 1'b0 && t < 100) begin
      step();
      t++;
    end
    check("inhibit_seen", 32'(t < 100), 32'd1);
    t = 0;
    while (ps2clk_line !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    check("clk_released", 32'(t < 200), 32'd1);
    check("start_bit", 32'(ps2dat_line), 32'd0);
    repeat (10) step();
    for (int k = 1; k <= nfall; k++) begin
      dev_clk_low = 1'b1;
      if (k == 5) fall5_cyc = cyc;
      if (k == rst_at) begin
        repeat (8) step();
        reset = 1'b1;
        step();
        check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2dat_oe), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_no_pulse", 32'({tx_done, tx_error}), 32'd0);
        reset       = 1'b0;
        dev_clk_low = 1'b0;
        return;
      end
      repeat (20) step();
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = ps2dat_line;
      if (k == 10 && ack) begin
        repeat (5) step();
        dev_dat_low = 1'b1;
        repeat (15) step();
      end else begin
        repeat (20) step();
      end
    end
    if (nfall == 11 && ack) begin
      repeat (3) step();
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    int t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 800) begin
      step();
      t++;
    end
    check("frame_end", 32'(t < 800), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         nfall;
    bit         ack;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t       vecs[7];
  logic [9:0] bits, bits2;
  int         d0, e0;
  logic [7:0] rnd;

  initial begin
    vecs[0] = '{8'hED, 11, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{8'h01, 11, 1'b1, 10'h201, 1, 0};
    vecs[2] = '{8'hFF, 11, 1'b1, 10'h3FF, 1, 0};
    vecs[3] = '{8'h00, 11, 1'b1, 10'h300, 1, 0};
    vecs[4] = '{8'h5A, 11, 1'b0, 10'h35A, 0, 1};
    vecs[5] = '{8'hAA, 0,  1'b1, 10'h000, 0, 1};
    vecs[6] = '{8'h3C, 5,  1'b1, 10'h000, 0, 1};

    repeat (3) step();
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_error", 32'(tx_error), 32'd0);
    check("reset_inhibit", 32'(rx_inhibit), 32'd0);
    check("reset_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("reset_dat_oe", 32'(ps2dat_oe), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      start_frame(vecs[i].data);
      dev_frame(vecs[i].nfall, vecs[i].ack, 0, bits);
      wait_end(d0, e0);
      if (vecs[i].nfall == 0) check_range("start_timeout_cyc", err_cyc - rel_cyc, 399, 401);
      if (vecs[i].nfall == 5) check_range("bit_timeout_cyc", err_cyc - fall5_cyc, 200, 206);
      repeat (5) step();
      check("clk_oe_run", 32'(last_run), 32'(InhCyc + 1));
      if (vecs[i].nfall >= 10) begin
        check("frame_bits_tbl", 32'(bits), 32'(vecs[i].exp_bits));
        check("frame_bits_model", 32'(bits), 32'(frame_model(vecs[i].data)));
      end
      check("done_pulses", 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      check("err_pulses", 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check("idle_clk_oe", 32'(ps2clk_oe), 32'd0);
      check("idle_dat_oe", 32'(ps2dat_oe), 32'd0);
      check("idle_ready", 32'(tx_ready), 32'd1);
    end

    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom);
      d0  = done_cnt;
      e0  = err_cnt;
      start_frame(rnd);
      dev_frame(11, 1'b1, 0, bits);
      wait_end(d0, e0);
      repeat (3) step();
      check("rand_bits", 32'(bits), 32'(frame_model(rnd)));
      check("rand_done", 32'(done_cnt - d0), 32'd1);
      check("rand_err", 32'(err_cnt - e0), 32'd0);
    end

    // Reset while the host is driving data bit 4, then a clean 0xFF frame.
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'h96);
    dev_frame(11, 1'b1, 4, bits);
    repeat (30) step();
    check("rst_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("rst_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("rst_idle_clk_oe", 32'(ps2clk_oe), 32'd0);
    d0 = done_cnt;
    start_frame(8'hFF);
    dev_frame(11, 1'b1, 0, bits);
    wait_end(d0, err_cnt);
    check("post_rst_bits", 32'(bits), 32'h3FF);
    check("post_rst_done", 32'(done_cnt - d0), 32'd1);

    // tx_valid held across DONE: second byte accepted straight away, later tx_data ignored.
    repeat (5) step();
    d0       = done_cnt;
    e0       = err_cnt;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_data = 8'hC5;
    dev_frame(11, 1'b1, 0, bits);
    wait_end(d0, e0);
    check("b2b_first_bits", 32'(bits), 32'(frame_model(8'h3C)));
    check("b2b_first_done", 32'(done_cnt - d0), 32'd1);
    begin
      int t = 0;
      while (tx_ready !== 1'b1 && t < 10) begin
        step();
        t++;
      end
      check("b2b_ready_again", 32'(t < 10), 32'd1);
    end
    step();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check("b2b_second_started", 32'(rx_inhibit), 32'd1);
    d0 = done_cnt;
    dev_frame(11, 1'b1, 0, bits2);
    wait_end(d0, e0);
    check("b2b_second_bits", 32'(bits2), 32'(frame_model(8'hC5)));
    check("b2b_second_done", 32'(done_cnt - d0), 32'd1);
    check("b2b_no_error", 32'(err_cnt - e0), 32'd0);

    repeat (5) step();
    check("ready_inhibit_consistent", 32'(inv_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
